// File: rtl/slc3_memio_pkg.sv
// Shared types and constants for the SLC-3 memory/IO controller.
package slc3_memio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE
   } state_e;

   localparam int unsigned IO_TAG_W = 4;
   localparam int unsigned WAIT_W   = 4;

   localparam logic [IO_TAG_W-1:0] SW_OFFSET = 4'hF;

endpackage

// File: rtl/memio_ctrl_if.sv
// CPU-side request/acknowledge bus of memio_ctrl.
// The be lane-enable signal exists only when MEMIO_BYTE_LANE_EN is defined.
interface memio_ctrl_if #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned CPU_ADDR_W = 16
) ();

   logic                  req;
   logic                  we;
   logic [CPU_ADDR_W-1:0] addr;
   logic [DATA_W-1:0]     wdata;
`ifdef MEMIO_BYTE_LANE_EN
   logic [1:0]            be;
`endif
   logic [DATA_W-1:0]     rdata;
   logic                  ack;
   logic                  busy;

   modport master (
      output req, we, addr, wdata,
`ifdef MEMIO_BYTE_LANE_EN
      output be,
`endif
      input  rdata, ack, busy
   );

   modport slave (
      input  req, we, addr, wdata,
`ifdef MEMIO_BYTE_LANE_EN
      input  be,
`endif
      output rdata, ack, busy
   );

endinterface

// File: rtl/memio_bus_buf.sv
// Tristate driver for the SRAM data bus plus the read-data register,
// which captures either the bus or an internal (IO) value.
module memio_bus_buf #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              drive_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              cap_en,
   input  logic              ld_en,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] rdata,
   inout  wire  [DATA_W-1:0] Data
);

   assign Data = drive_en ? wdata : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (cap_en) begin
         rdata <= Data;
      end else if (ld_en) begin
         rdata <= ld_data;
      end
   end

endmodule

// File: rtl/memio_ctrl.sv
// Req/ack memory and IO controller: SRAM access with WAIT_STATES extra cycles,
// N_IO memory-mapped output registers and a synchronised switch input.
// Optional byte-lane enables under MEMIO_BYTE_LANE_EN.
module memio_ctrl
   import slc3_memio_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned CPU_ADDR_W  = 16,
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned N_IO        = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   memio_ctrl_if.slave              bus,
   input  logic [DATA_W-1:0]        Switches,
   output logic [N_IO*DATA_W-1:0]   io_out,
   output logic                     Mem_CE,
   output logic                     Mem_OE,
   output logic                     Mem_WE,
   output logic                     Mem_UB,
   output logic                     Mem_LB,
   output logic [ADDR_W-1:0]        Mem_ADDR,
   inout  wire  [DATA_W-1:0]        Data
);

   state_e              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                drive_en;
   logic                ack_q;
   logic                busy_q;
   logic                ce_n, oe_n, we_n, ub_n, lb_n;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   sw_meta, sw_sync;
   logic [DATA_W-1:0]   io_reg [N_IO];

   logic                accept_c;
   logic                io_hit_c;
   logic [IO_TAG_W-1:0] io_ofs_c;
   logic [DATA_W-1:0]   io_rd_c;
   logic                cap_en_c;
   logic                ld_en_c;
   logic                ub_c, lb_c;

   assign accept_c = (state == ST_IDLE) && bus.req;
   assign io_hit_c = &bus.addr[CPU_ADDR_W-1:IO_TAG_W];
   assign io_ofs_c = bus.addr[IO_TAG_W-1:0];
   assign cap_en_c = (state == ST_ACCESS) && (wait_cnt == '0) && !we_q;
   assign ld_en_c  = accept_c && io_hit_c && !bus.we;

   // Lane strobes for an SRAM access: reads always use both lanes
`ifdef MEMIO_BYTE_LANE_EN
   assign ub_c = bus.we ? ~bus.be[1] : 1'b0;
   assign lb_c = bus.we ? ~bus.be[0] : 1'b0;
`else
   assign ub_c = 1'b0;
   assign lb_c = 1'b0;
`endif

   // IO read mux: output registers, switch port, otherwise zero
   always_comb begin
      io_rd_c = '0;
      if (io_ofs_c == SW_OFFSET) begin
         io_rd_c = sw_sync;
      end
      for (int unsigned k = 0; k < N_IO; k++) begin
         if (io_ofs_c == IO_TAG_W'(k)) begin
            io_rd_c = io_reg[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= Switches;
         sw_sync <= sw_meta;
      end
   end

   // IO writes land on acceptance so the value is visible in the ack cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < N_IO; k++) begin
            io_reg[k] <= '0;
         end
      end else if (accept_c && io_hit_c && bus.we) begin
         for (int unsigned k = 0; k < N_IO; k++) begin
            if (io_ofs_c == IO_TAG_W'(k)) begin
               io_reg[k] <= bus.wdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         drive_en <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         ce_n     <= 1'b1;
         oe_n     <= 1'b1;
         we_n     <= 1'b1;
         ub_n     <= 1'b1;
         lb_n     <= 1'b1;
         mem_addr <= '0;
      end else begin
         ack_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  busy_q  <= 1'b1;
                  we_q    <= bus.we;
                  wdata_q <= bus.wdata;
                  if (io_hit_c) begin
                     state <= ST_DONE;
                     ack_q <= 1'b1;
                  end else begin
                     state    <= ST_ACCESS;
                     wait_cnt <= WAIT_W'(WAIT_STATES);
                     mem_addr <= ADDR_W'(bus.addr);
                     ce_n     <= 1'b0;
                     oe_n     <= bus.we;
                     we_n     <= ~bus.we;
                     ub_n     <= ub_c;
                     lb_n     <= lb_c;
                     drive_en <= bus.we;
                  end
               end
            end
            ST_ACCESS: begin
               if (wait_cnt == '0) begin
                  state <= ST_DONE;
                  ack_q <= 1'b1;
                  ce_n  <= 1'b1;
                  oe_n  <= 1'b1;
                  we_n  <= 1'b1;
                  ub_n  <= 1'b1;
                  lb_n  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end
            ST_DONE: begin
               // write data is still driven during this cycle for SRAM hold time
               state    <= ST_IDLE;
               busy_q   <= 1'b0;
               drive_en <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   memio_bus_buf #(.DATA_W(DATA_W)) u_bus_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .drive_en (drive_en),
      .wdata    (wdata_q),
      .cap_en   (cap_en_c),
      .ld_en    (ld_en_c),
      .ld_data  (io_rd_c),
      .rdata    (bus.rdata),
      .Data     (Data)
   );

   for (genvar k = 0; k < N_IO; k++) begin : g_io_out
      assign io_out[k*DATA_W +: DATA_W] = io_reg[k];
   end

   assign bus.ack  = ack_q;
   assign bus.busy = busy_q;
   assign Mem_CE   = ce_n;
   assign Mem_OE   = oe_n;
   assign Mem_WE   = we_n;
   assign Mem_UB   = ub_n;
   assign Mem_LB   = lb_n;
   assign Mem_ADDR = mem_addr;

endmodule
